// File: rtl/cpu_run_sequencer.sv
// Batch controller: queues CPU program start addresses, launches each program,
// times the run until done (or timeout) and reports one result per program.
//
// state  | meaning
// IDLE   | waiting for a queued address; pops the FIFO head when one is present
// LAUNCH | one-cycle start pulse to the CPU; counter and arming cleared
// RUN    | counting cycles until an armed done or the timeout limit
// REPORT | result held on the valid/ready port until accepted
module cpu_run_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 32767
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    output logic              full_o,
    output logic              busy_o,
    output logic              cpu_start_o,
    output logic [ADDR_W-1:0] cpu_start_addr_o,
    input  logic              cpu_done_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [ADDR_W-1:0] result_addr_o,
    output logic [CNT_W-1:0]  result_cycles_o,
    output logic              result_timeout_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT    = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_empty, push_ok, pop;

    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  counter, counter_inc;
    logic              armed, done_acc, timeout_hit;

    assign fifo_empty  = (fifo_cnt == '0);
    assign full_o      = (fifo_cnt == FULL_CNT);
    assign push_ok     = push_i && !full_o;
    assign busy_o      = (state != IDLE) || !fifo_empty;
    assign counter_inc = counter + CNT_W'(1);

    assign cpu_start_o      = (state == LAUNCH);
    assign cpu_start_addr_o = cur_addr;

    // Storage needs no reset: occupancy is tracked by fifo_cnt alone.
    always_ff @(posedge clock_i) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_addr_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)      fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
            else if (!push_ok && pop) fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        done_acc    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = RUN;
            RUN: begin
                done_acc    = armed && cpu_done_i;
                timeout_hit = !done_acc && (counter_inc == TIMEOUT_CNT);
                if (done_acc || timeout_hit) state_nxt = REPORT;
            end
            REPORT: begin
                if (result_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arming on a sampled low keeps a done level left over from the
    // previous program from ending the new run immediately.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cur_addr         <= '0;
            counter          <= '0;
            armed            <= 1'b0;
            result_valid_o   <= 1'b0;
            result_addr_o    <= '0;
            result_cycles_o  <= '0;
            result_timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) cur_addr <= fifo_mem[rd_ptr];
                end
                LAUNCH: begin
                    counter <= '0;
                    armed   <= 1'b0;
                end
                RUN: begin
                    counter <= counter_inc;
                    if (!cpu_done_i) armed <= 1'b1;
                    if (done_acc || timeout_hit) begin
                        result_valid_o   <= 1'b1;
                        result_addr_o    <= cur_addr;
                        result_cycles_o  <= done_acc ? counter_inc : TIMEOUT_CNT;
                        result_timeout_o <= timeout_hit;
                    end
                end
                REPORT: begin
                    if (result_ready_i) result_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Scoreboard bench for cpu_run_sequencer: a behavioural CPU drives done levels,
// expected results come from each program's done profile and the timeout rule.
module tb_cpu_run_sequencer;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 15;
    localparam int DEPTH  = 4;
    localparam int TMO    = 50;

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              push_i = 1'b0;
    logic [ADDR_W-1:0] push_addr_i = '0;
    logic              full_o, busy_o, cpu_start_o;
    logic [ADDR_W-1:0] cpu_start_addr_o;
    logic              cpu_done_i = 1'b0;
    logic              result_valid_o;
    logic              result_ready_i = 1'b0;
    logic [ADDR_W-1:0] result_addr_o;
    logic [CNT_W-1:0]  result_cycles_o;
    logic              result_timeout_o;

    cpu_run_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .push_i(push_i), .push_addr_i(push_addr_i),
        .full_o(full_o), .busy_o(busy_o), .cpu_start_o(cpu_start_o),
        .cpu_start_addr_o(cpu_start_addr_o), .cpu_done_i(cpu_done_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_addr_o(result_addr_o), .result_cycles_o(result_cycles_o),
        .result_timeout_o(result_timeout_o)
    );

    always #5 clock_i = ~clock_i;

    // s: done forced high in RUN cycles 1..s; d: done rises at RUN cycle d (0 = never)
    typedef struct {int s; int d;} prof_t;
    typedef struct {logic [ADDR_W-1:0] addr; int cycles; bit to;} res_t;

    prof_t             prof_q[$];
    logic [ADDR_W-1:0] launch_q[$];
    res_t              res_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, expect_launch_at = 0, launches = 0, ready_mode = 0;
    prof_t cur_prof;
    bit cpu_active = 0;
    int run_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic prof_t mk(input int s, input int d);
        prof_t p;
        p.s = s;
        p.d = d;
        return p;
    endfunction

    function automatic prof_t rand_prof();
        int s, d;
        s = $urandom_range(4, 0);
        d = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(60, s + 2));
        return mk(s, d);
    endfunction

    // Run ends at the first armed done; beyond TMO cycles the run is abandoned.
    function automatic res_t model(input logic [ADDR_W-1:0] a, input prof_t p);
        res_t r;
        r.addr = a;
        if (p.d != 0 && p.d <= TMO) begin
            r.cycles = p.d;
            r.to     = 0;
        end else begin
            r.cycles = TMO;
            r.to     = 1;
        end
        return r;
    endfunction

    always @(posedge clock_i) cyc++;

    always @(posedge clock_i) begin
        #1;
        case (ready_mode)
            0:       result_ready_i = 1'($urandom_range(1, 0));
            1:       result_ready_i = 1'b0;
            default: result_ready_i = 1'b1;
        endcase
    end

    always @(posedge clock_i) begin
        #2;
        if (reset_i) begin
            cpu_active = 0;
            cpu_done_i = 1'b0;
        end else if (cpu_active) begin
            run_cyc++;
            if (run_cyc <= cur_prof.s)                        cpu_done_i = 1'b1;
            else if (cur_prof.d != 0 && run_cyc >= cur_prof.d) cpu_done_i = 1'b1;
            else                                              cpu_done_i = 1'b0;
        end
    end

    logic              held_v = 0, held_r = 0, prev_start = 0;
    logic [ADDR_W-1:0] h_addr;
    logic [CNT_W-1:0]  h_cyc;
    logic              h_to;

    always @(negedge clock_i) begin
        if (!reset_i) begin
            if (prev_start) chk("start_one_cycle", cpu_start_o, 0);
            if (cpu_start_o) begin
                launches++;
                if (launch_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_launch: addr %0d launched, none pending", cpu_start_addr_o);
                end else begin
                    chk("launch_addr", cpu_start_addr_o, launch_q.pop_front());
                end
                if (prof_q.size() > 0) begin
                    cur_prof   = prof_q.pop_front();
                    cpu_active = 1;
                    run_cyc    = 0;
                end
                if (expect_launch_at != 0) begin
                    chk("launch_cycle", cyc, expect_launch_at);
                    expect_launch_at = 0;
                end
            end
            if (held_v && !held_r) begin
                chk("valid_held", result_valid_o, 1);
                chk("addr_stable", result_addr_o, h_addr);
                chk("cycles_stable", result_cycles_o, h_cyc);
                chk("timeout_stable", result_timeout_o, h_to);
            end
            if (result_valid_o) begin
                chk("no_start_in_report", cpu_start_o, 0);
                if (result_ready_i) begin
                    if (res_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: addr %0d reported, none pending", result_addr_o);
                    end else begin
                        res_t e;
                        e = res_q.pop_front();
                        chk("result_addr", result_addr_o, e.addr);
                        chk("result_cycles", result_cycles_o, e.cycles);
                        chk("result_timeout", result_timeout_o, e.to);
                    end
                    if (launch_q.size() > 0) expect_launch_at = cyc + 2;
                end
            end
            held_v     = result_valid_o;
            held_r     = result_ready_i;
            h_addr     = result_addr_o;
            h_cyc      = result_cycles_o;
            h_to       = result_timeout_o;
            prev_start = cpu_start_o;
        end else begin
            held_v     = 0;
            prev_start = 0;
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that sampled the push.
    task automatic push_prog(input logic [ADDR_W-1:0] a, input prof_t p,
                             input bit accept, input bit chk_lat);
        push_i      = 1'b1;
        push_addr_i = a;
        if (accept) begin
            launch_q.push_back(a);
            prof_q.push_back(p);
            res_q.push_back(model(a, p));
        end
        if (chk_lat) expect_launch_at = cyc + 2;
        @(posedge clock_i);
        #1;
        push_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_o || res_q.size() != 0) && n < 4000) begin
            @(posedge clock_i);
            #1;
            n++;
        end
        if (n >= 4000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: still busy after %0d cycles, %0d results pending", name, n, res_q.size());
        end else begin
            chk({name, "_busy"}, busy_o, 0);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_full"}, full_o, 0);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_start"}, cpu_start_o, 0);
        chk({name, "_start_addr"}, cpu_start_addr_o, 0);
        chk({name, "_valid"}, result_valid_o, 0);
        chk({name, "_raddr"}, result_addr_o, 0);
        chk({name, "_rcycles"}, result_cycles_o, 0);
        chk({name, "_rtimeout"}, result_timeout_o, 0);
    endtask

    initial begin
        int n, l0;
        reset_i = 1'b1;
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        chk_all_zero("reset");
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        @(posedge clock_i);
        #1;

        // single run, launch two cycles after the push
        push_prog(8'd93, mk(0, 40), 1, 1);
        wait_idle("single");

        // previous done left high through LAUNCH and early RUN
        push_prog(8'd77, mk(3, 9), 1, 1);
        wait_idle("stale");

        // timeout followed by a queued program
        push_prog(8'd200, mk(0, 0), 1, 1);
        push_prog(8'd5, mk(1, 12), 1, 0);
        wait_idle("timeout");

        // fill the FIFO behind a running program, then hold the result back
        ready_mode = 1;
        push_prog(8'd1, mk(0, 30), 1, 1);
        repeat (3) @(posedge clock_i);
        #1;
        push_prog(8'd93, rand_prof(), 1, 0);
        push_prog(8'd138, rand_prof(), 1, 0);
        push_prog(8'd10, rand_prof(), 1, 0);
        push_prog(8'd20, rand_prof(), 1, 0);
        chk("full_after_4", full_o, 1);
        push_prog(8'd55, rand_prof(), 0, 0);
        chk("full_after_drop", full_o, 1);
        n = 0;
        while (!result_valid_o && n < 200) begin
            @(posedge clock_i);
            #1;
            n++;
        end
        chk("blocker_result_seen", result_valid_o, 1);
        repeat (10) @(posedge clock_i);
        #1;
        chk("backpressure_full", full_o, 1);
        ready_mode = 2;
        repeat (20) @(posedge clock_i);
        ready_mode = 0;
        wait_idle("queue");

        // reset in RUN cycle 5 with two programs still queued
        l0 = launches;
        push_prog(8'd40, mk(0, 0), 1, 1);
        push_prog(8'd41, rand_prof(), 1, 0);
        push_prog(8'd42, rand_prof(), 1, 0);
        n = 0;
        while (!(launches > l0 && cpu_active && run_cyc == 4) && n < 200) begin
            @(posedge clock_i);
            #1;
            n++;
        end
        chk("reached_run_cycle5", run_cyc, 4);
        reset_i = 1'b1;
        launch_q.delete();
        prof_q.delete();
        res_q.delete();
        expect_launch_at = 0;
        @(posedge clock_i);
        @(negedge clock_i);
        chk_all_zero("midrun_reset");
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        l0 = launches;
        repeat (10) @(posedge clock_i);
        #1;
        chk("no_launch_after_reset", launches, l0);
        chk("idle_after_reset", busy_o, 0);

        // randomized programs with random gaps and random ready
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (launch_q.size() >= DEPTH && n < 1000) begin
                @(posedge clock_i);
                #1;
                n++;
            end
            repeat ($urandom_range(5, 0)) @(posedge clock_i);
            #1;
            if (launch_q.size() < DEPTH)
                push_prog(8'($urandom_range(255, 0)), rand_prof(), 1, 0);
        end
        wait_idle("random");
        chk("launch_queue_empty", launch_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
